inbox_fifo: RTL and testbench
=============================

Name: inbox_fifo

Overview:
- Input queue of the HRM CPU. It holds the values that the loader or testbench pushes in.
- It presents the oldest value to the accumulator register's inbox mux input as a first-word-fall-through head.
- The control unit pops one value per INBOX instruction, in the same cycle that the register latches it (wR=1, muxR=2'b00).
- The control unit reads the empty flag to halt the program when INBOX executes on an empty queue.

Parameters:
- DATA_W, 8, width of one queue entry. It matches the register's iInbox width.
- DEPTH, 32, number of entries. It must be a power of 2 and at least 2.
- ADDR_W, 5, pointer width. It equals log2(DEPTH).

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- iData  input  DATA_W  value pushed by the loader.
- wr  input  1  push strobe from the loader, one entry per cycle while high.
- rd  input  1  pop strobe from the control unit, asserted with the register's wR during INBOX.
- oData  output  DATA_W  head entry. Wired to the register's iInbox.
- empty  output  1  queue holds 0 entries.
- full  output  1  queue holds DEPTH entries.
- count  output  ADDR_W+1  number of entries held, 0..DEPTH.
- ovf  output  1  sticky flag: a push was attempted while full.
- udf  output  1  sticky flag: a pop was attempted while empty.
- clr  input  1  synchronous flush of queue and sticky flags (program restart).

Behaviour:
- Reset (rst_n=0, asynchronous):
  - wr_ptr=0, rd_ptr=0, count=0.
  - empty=1, full=0, ovf=0, udf=0.
  - oData is don't-care while empty. The implementation drives it to 0.
  - Memory contents are not reset.
- Storage: DEPTH x DATA_W array with synchronous write and asynchronous read.
  - oData = mem[rd_ptr] combinationally.
  - The register therefore samples the head in the same edge that pops it.
- Push: on a rising edge with wr=1 and full=0:
  - mem[wr_ptr] <= iData.
  - wr_ptr increments modulo DEPTH (natural wrap of ADDR_W bits).
- Pop: on a rising edge with rd=1 and empty=0, rd_ptr increments modulo DEPTH.
- Latency: a pushed word is visible on oData in the cycle after the push edge, with empty deasserted. Write-to-read latency is 1 cycle.
- Count update per edge:
  - +1 for an accepted push only.
  - -1 for an accepted pop only.
  - Unchanged for both or neither.
- Flags: empty=(count==0) and full=(count==DEPTH). Both are decoded from the registered count, so they are glitch-free.
- Simultaneous wr and rd:
  - Non-empty and non-full: both are accepted and count is unchanged.
  - Full: the pop is accepted and the push is rejected. ovf is set and count becomes DEPTH-1. There is no same-cycle pass-through.
  - Empty: the push is accepted and the pop is rejected. udf is set and count becomes 1. There is no bypass; oData shows the new word on the next cycle.
- Rejected operations leave memory and pointers untouched. Only ovf or udf changes.
- ovf and udf stay set until clr or reset.
- clr=1 at an edge:
  - Pointers, count, ovf and udf go to 0, overriding any wr or rd in that cycle.
  - empty=1.
- rst_n asserted mid-operation immediately forces the reset state; the contents of a partially filled queue are discarded.
- No state machine beyond pointers and count. count is the single source of truth for the flags.

Decomposition:
- Shared package hrm_pkg:
  - DATA_W=8 word-width constant, used by the register, ALU, memory and outbox.
  - Mux select constants MUXR_INBOX=2'b00, MUXR_MEM=2'b01, MUXR_ALU=2'b11.
- Natural sub-module: fifo_mem, the DEPTH x DATA_W array with one synchronous write port and one asynchronous read port.
- inbox_fifo holds the pointers, count, flags and clr logic.
- The same pair is reused for a later outbox_fifo.

Test Plan:
- Reset with no stimulus -> empty=1, full=0, count=0, ovf=0, udf=0, oData=0.
- Push 8'h05, 8'hFE, 8'h80 on consecutive cycles, then pop 3 -> oData shows 05, FE, 80 in order. count goes 1,2,3,2,1,0 and empty=1 at the end.
- Fill 32 entries with 0..31, push 8'hAA -> full=1 and ovf=1, count=32. Draining 32 pops returns 0..31 and never AA.
- Pop while empty -> udf=1, count stays 0, rd_ptr unchanged. A following push of 8'h11 then pop returns 11.
- Simultaneous wr and rd at count=5 for 40 cycles with incrementing data -> count stays 5, pointers wrap past 31, and the output order matches the reference queue model.
- Assert rst_n=0 asynchronously (mid-cycle) at count=10 with ovf set -> outputs go to reset values before the next edge.
- Assert clr=1 together with wr=1 and rd=1 at count=7 -> count=0, empty=1, ovf=0, udf=0.

Source files
------------

// File: rtl/hrm_pkg.sv
// Shared HRM CPU constants: datapath word width and accumulator mux selects.
package hrm_pkg;
    localparam int DATA_W = 8;

    localparam logic [1:0] MUXR_INBOX = 2'b00;
    localparam logic [1:0] MUXR_MEM   = 2'b01;
    localparam logic [1:0] MUXR_ALU   = 2'b11;
endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W storage: one synchronous write port, one asynchronous read port.
module fifo_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    // Contents are intentionally not reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/inbox_fifo.sv
// HRM inbox queue: first-word-fall-through head, count-derived flags,
// sticky over/underflow and a synchronous flush for program restart.
module inbox_fifo
    import hrm_pkg::*;
#(
    parameter int DATA_W = hrm_pkg::DATA_W,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] iData,
    input  logic              wr,
    input  logic              rd,
    input  logic              clr,
    output logic [DATA_W-1:0] oData,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              ovf,
    output logic              udf
);
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [DATA_W-1:0] head;
    logic              push_ok, pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == (ADDR_W+1)'(DEPTH));
    assign push_ok = wr & ~full;
    assign pop_ok  = rd & ~empty;

    fifo_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
        .clk   (clk),
        .we    (push_ok & ~clr),
        .waddr (wr_ptr),
        .wdata (iData),
        .raddr (rd_ptr),
        .rdata (head)
    );

    // Head is meaningless while empty; hold it at zero so the register sees a clean value.
    assign oData = empty ? '0 : head;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            udf    <= 1'b0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            udf    <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + ADDR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (ADDR_W+1)'(1);
                2'b01:   count <= count - (ADDR_W+1)'(1);
                default: count <= count;
            endcase
            if (wr && full)  ovf <= 1'b1;
            if (rd && empty) udf <= 1'b1;
        end
    end
endmodule

// File: tb/tb_inbox_fifo.sv
// Directed bench for inbox_fifo with a small reference queue for the wrap test.
module tb_inbox_fifo;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] iData;
    logic       wr, rd, clr;
    logic [7:0] oData;
    logic       empty, full, ovf, udf;
    logic [5:0] count;

    int passed = 0;
    int total  = 0;
    logic [7:0] q[$];
    logic [7:0] nxt;

    inbox_fifo dut (
        .clk(clk), .rst_n(rst_n), .iData(iData), .wr(wr), .rd(rd), .clr(clr),
        .oData(oData), .empty(empty), .full(full), .count(count), .ovf(ovf), .udf(udf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic push(input logic [7:0] d);
        wr = 1'b1; iData = d; tick(); wr = 1'b0;
    endtask

    task automatic pop();
        rd = 1'b1; tick(); rd = 1'b0;
    endtask

    task automatic flush();
        clr = 1'b1; tick(); clr = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; wr = 1'b0; rd = 1'b0; clr = 1'b0; iData = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_empty", empty, 1);
        check("rst_full",  full,  0);
        check("rst_count", count, 0);
        check("rst_ovf",   ovf,   0);
        check("rst_udf",   udf,   0);
        check("rst_odata", oData, 0);
        rst_n = 1'b1;
        tick();

        // In-order push/pop
        push(8'h05); check("p1_count", count, 1); check("p1_empty", empty, 0); check("p1_head", oData, 8'h05);
        push(8'hFE); check("p2_count", count, 2);
        push(8'h80); check("p3_count", count, 3);
        check("pop1_head", oData, 8'h05); pop(); check("pop1_count", count, 2);
        check("pop2_head", oData, 8'hFE); pop(); check("pop2_count", count, 1);
        check("pop3_head", oData, 8'h80); pop(); check("pop3_count", count, 0);
        check("pop3_empty", empty, 1);

        // Fill to full, overflow, drain
        for (int i = 0; i < 32; i++) push(8'(i));
        check("fill_full", full, 1); check("fill_count", count, 32);
        push(8'hAA);
        check("ovf_set", ovf, 1); check("ovf_count", count, 32); check("ovf_full", full, 1);
        for (int i = 0; i < 32; i++) begin
            check("drain_head", oData, i);
            pop();
        end
        check("drain_empty", empty, 1); check("drain_ovf_sticky", ovf, 1);
        flush();
        check("clr_ovf", ovf, 0);

        // Underflow, then normal traffic still in order
        pop();
        check("udf_set", udf, 1); check("udf_count", count, 0); check("udf_empty", empty, 1);
        push(8'h11); check("udf_head", oData, 8'h11);
        pop(); check("udf_after_count", count, 0);
        wr = 1'b1; rd = 1'b1; iData = 8'h22; tick(); wr = 1'b0; rd = 1'b0;
        check("empty_wr_rd_count", count, 1); check("empty_wr_rd_head", oData, 8'h22);
        pop();
        flush();
        check("clr_udf", udf, 0);

        // Steady wr+rd at count=5, pointers wrap
        nxt = 8'h00;
        q.delete();
        for (int i = 0; i < 5; i++) begin push(nxt); q.push_back(nxt); nxt++; end
        for (int i = 0; i < 40; i++) begin
            check("wrap_head", oData, q[0]);
            wr = 1'b1; rd = 1'b1; iData = nxt; tick();
            void'(q.pop_front()); q.push_back(nxt); nxt++;
            check("wrap_count", count, 5);
        end
        wr = 1'b0; rd = 1'b0;
        check("wrap_final_head", oData, q[0]);
        flush();

        // Full with wr+rd: pop wins, push rejected, ovf set
        for (int i = 0; i < 32; i++) push(8'h40 + 8'(i));
        wr = 1'b1; rd = 1'b1; iData = 8'hEE; tick(); wr = 1'b0; rd = 1'b0;
        check("full_wr_rd_count", count, 31); check("full_wr_rd_ovf", ovf, 1);
        check("full_wr_rd_head", oData, 8'h41);
        repeat (21) pop();
        check("pre_rst_count", count, 10);

        // Asynchronous reset mid-cycle
        #2 rst_n = 1'b0;
        #1;
        check("arst_count", count, 0); check("arst_empty", empty, 1);
        check("arst_ovf", ovf, 0); check("arst_odata", oData, 0); check("arst_full", full, 0);
        @(negedge clk); rst_n = 1'b1;
        tick();

        // clr beats simultaneous wr/rd
        pop(); check("pre_clr_udf", udf, 1);
        for (int i = 0; i < 7; i++) push(8'h70 + 8'(i));
        check("pre_clr_count", count, 7);
        clr = 1'b1; wr = 1'b1; rd = 1'b1; iData = 8'h99; tick();
        clr = 1'b0; wr = 1'b0; rd = 1'b0;
        check("clr_count", count, 0); check("clr_empty", empty, 1);
        check("clr_ovf2", ovf, 0); check("clr_udf2", udf, 0);
        push(8'h33); check("post_clr_head", oData, 8'h33);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
